exposure_sequencer: RTL and testbench
=====================================

Name: exposure_sequencer

Overview:
- Next-generation, parametrised camera exposure timing engine driving NUM_CH sensor trigger lines and one strobe output.
- Each channel has its own start delay and width inside one exposure cycle.
- Cycle source is selectable: free-running frame timer (re-synchronised by PPS), external trigger edge, or software pulse.
- Reports busy, frame count and missed triggers to the register block.

Parameters:
- NUM_CH, 3, number of sensor trigger channels (1..8)
- TW, 32, width of all timing values and timers, in µs
- STROBE_REF, 0, index of the channel whose trigger gates the strobe

Ports:
- aclk  in  1  system clock
- aresetn  in  1  asynchronous active-low reset
- tick_us  in  1  one-cycle pulse per µs
- tick_sec  in  1  one-cycle PPS pulse
- external_trigger  in  1  asynchronous external trigger input
- sw_trigger  in  1  one-cycle software trigger pulse
- trig_mode  in  2  0 free-run, 1 external, 2 software, 3 disabled
- exposure_enable  in  1  level; low forces idle
- FRAME_PERIOD  in  TW  free-run frame period, µs
- EXP_DELAY  in  NUM_CH*TW  per-channel start delay, channel i at [i*TW +: TW]
- EXP_WIDTH  in  NUM_CH*TW  per-channel exposure width, same packing
- STROBE_PERIOD  in  TW  strobe repetition period, µs
- STROBE_WIDTH  in  TW  strobe high time, µs
- sensor_trigger  out  NUM_CH  registered exposure outputs
- strobe_enable  out  1  registered strobe output
- busy  out  1  high while an exposure cycle runs
- frame_count  out  16  accepted exposure cycles, wraps at 0xFFFF→0
- trig_missed  out  1  one-cycle pulse when a start arrives while busy

Behaviour:
- **Reset.** All outputs are 0; timers are 0; FSM is IDLE.
- **Frame timer.**
  - On tick_sec: load 0.
  - Else on tick_us: load 0 if timer+1 ≥ FRAME_PERIOD, else increment.
  - Free-run start pulse fires on any cycle in which 0 is loaded.
  - FRAME_PERIOD 0 or 1 gives a start on every tick_us.
- **External trigger.** Two-flop synchroniser plus rising-edge detect. Start pulse appears 3 aclk after the input edge.
- **Start selection.** start = mode-selected pulse. In mode 3 there is never a start.
- **FSM states.** IDLE and RUN.
- **IDLE with start.**
  - Latch EXP_DELAY/EXP_WIDTH into shadow registers.
  - Compute end_i = delay_i + width_i at TW+1 bits.
  - end_max = max of end_i, registered one cycle after the latch. end_max is valid by the first tick_us in any case.
  - cyc_t ← 0, go to RUN, frame_count +1.
- **RUN.**
  - cyc_t increments on tick_us.
  - When cyc_t ≥ end_max: return to IDLE, or reload if start is present that same cycle. A reload is back-to-back: frame_count +1, no miss.
- **Missed trigger.** start in RUN with cyc_t < end_max → trig_missed pulse. The running cycle and latched values are unaffected.
- **Channel output.** sensor_trigger[i] (registered) = RUN && delay_i ≤ cyc_t < end_i.
  - Latency with delay 0: high 2 aclk after the start pulse.
  - width_i = 0: the channel stays low.
  - All widths 0: RUN lasts 1–2 cycles and outputs stay low.
- **busy.** busy = (state == RUN), registered.
- **exposure_enable low.** Synchronous: FSM to IDLE; cyc_t, sensor_trigger, strobe and busy cleared next cycle. frame_count holds. A cycle in progress is aborted.
- **Strobe timer.**
  - Cleared while sensor_trigger[STROBE_REF] is low.
  - Otherwise on tick_us: wraps to 0 when timer+1 ≥ STROBE_PERIOD, else increments.
  - strobe_enable (registered) = ref_trigger && strobe_timer < STROBE_WIDTH.
  - STROBE_WIDTH ≥ STROBE_PERIOD gives a continuous strobe during exposure.
- **Mid-cycle register writes.** Changing inputs mid-cycle has no effect until the next accepted start.

Optional Feature:
- Macro: EXPOSURE_SEQ_TRIG_FILTER_EN.
- Defined:
  - The synchronised external trigger passes through a 4-cycle stable-level filter before edge detection. The level changes only after 4 consecutive equal samples.
  - External start latency becomes 7 aclk.
  - Pulses shorter than 4 aclk are ignored.
- Undefined: no filter; latency 3 aclk; any pulse of at least 1 synchronised sample triggers.

Test Plan:
- Free-run, FRAME_PERIOD=100, DELAY={0,10,20}, WIDTH={50,30,40}, tick_us every 4 aclk:
  - ch0 high µs 0–49, ch1 µs 10–39, ch2 µs 20–59.
  - frame_count increments every 100 µs.
- tick_sec asserted at µs 57 of a free-run frame → frame timer restarts. New cycle starts only after the running cycle ends at µs 60; no glitch on outputs.
- External mode, WIDTH0=20, edges 10 µs apart → second edge gives trig_missed=1 for one cycle; frame_count +1 only. An edge at exactly cyc_t=end_max reloads back-to-back.
- Strobe with ref ch0 width 50, STROBE_PERIOD=10, STROBE_WIDTH=3 → strobe high µs 0–2, 10–12, …, 40–42; low after ch0 falls.
- exposure_enable dropped at µs 15 of a cycle → all outputs low next cycle; busy=0; frame_count unchanged; next start accepted normally.
- With EXPOSURE_SEQ_TRIG_FILTER_EN:
  - 3-cycle external pulse → no start.
  - 6-cycle pulse → sensor_trigger[0] rises 8 aclk after the input edge (7 filter/sync + 1 register; delay 0).

Source files
------------

// File: rtl/exposure_sequencer.sv
// Camera exposure timing engine: per-channel trigger windows inside one exposure cycle plus a gated strobe.
// Optional EXPOSURE_SEQ_TRIG_FILTER_EN adds a 4-sample stable-level filter on the external trigger.
module exposure_sequencer #(
   parameter int NUM_CH     = 3,
   parameter int TW         = 32,
   parameter int STROBE_REF = 0
) (
   input  logic                 aclk,
   input  logic                 aresetn,
   input  logic                 tick_us,
   input  logic                 tick_sec,
   input  logic                 external_trigger,
   input  logic                 sw_trigger,
   input  logic [1:0]           trig_mode,
   input  logic                 exposure_enable,
   input  logic [TW-1:0]        FRAME_PERIOD,
   input  logic [NUM_CH*TW-1:0] EXP_DELAY,
   input  logic [NUM_CH*TW-1:0] EXP_WIDTH,
   input  logic [TW-1:0]        STROBE_PERIOD,
   input  logic [TW-1:0]        STROBE_WIDTH,
   output logic [NUM_CH-1:0]    sensor_trigger,
   output logic                 strobe_enable,
   output logic                 busy,
   output logic [15:0]          frame_count,
   output logic                 trig_missed
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              state_r;
   logic [TW-1:0]       frame_t_r;
   logic [TW:0]         frame_inc_s;
   logic                fr_start_s;
   logic                ext_meta_r, ext_sync_r, ext_prev_r;
   logic                ext_level_s, ext_start_s;
   logic                start_s, run_done_s, accept_s, miss_s;
   logic [TW-1:0]       delay_sh_r [NUM_CH];
   logic [TW-1:0]       width_sh_r [NUM_CH];
   logic [TW:0]         end_s      [NUM_CH];
   logic [TW:0]         end_max_s, end_max_r;
   logic [TW-1:0]       cyc_t_r;
   logic [NUM_CH-1:0]   trig_s;
   logic [TW-1:0]       strobe_t_r;
   logic [TW:0]         strobe_inc_s;
   logic                ref_trig_s;

   // Free-run frame timer: next value and start pulse on every reload to zero
   always_comb begin
      frame_inc_s = {1'b0, frame_t_r} + {{TW{1'b0}}, 1'b1};
      fr_start_s  = tick_sec | (tick_us & (frame_inc_s >= {1'b0, FRAME_PERIOD}));
   end

   // Frame timer register, PPS forces realignment
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         frame_t_r <= {TW{1'b0}};
      else if (tick_sec)
         frame_t_r <= {TW{1'b0}};
      else if (tick_us)
         frame_t_r <= (frame_inc_s >= {1'b0, FRAME_PERIOD}) ? {TW{1'b0}} : frame_inc_s[TW-1:0];
   end

   // Two-flop synchroniser and edge-detect history for the external trigger
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ext_meta_r <= 1'b0;
         ext_sync_r <= 1'b0;
         ext_prev_r <= 1'b0;
      end else begin
         ext_meta_r <= external_trigger;
         ext_sync_r <= ext_meta_r;
         ext_prev_r <= ext_level_s;
      end
   end

`ifdef EXPOSURE_SEQ_TRIG_FILTER_EN
   logic       ext_filt_r;
   logic [1:0] filt_cnt_r;

   // Level follows the synchronised input only after four consecutive differing samples
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ext_filt_r <= 1'b0;
         filt_cnt_r <= 2'd0;
      end else if (ext_sync_r == ext_filt_r) begin
         filt_cnt_r <= 2'd0;
      end else if (filt_cnt_r == 2'd3) begin
         ext_filt_r <= ext_sync_r;
         filt_cnt_r <= 2'd0;
      end else begin
         filt_cnt_r <= filt_cnt_r + 2'd1;
      end
   end

   assign ext_level_s = ext_filt_r;
`else
   assign ext_level_s = ext_sync_r;
`endif

   assign ext_start_s = ext_level_s & ~ext_prev_r;

   // Start source selection and FSM decisions
   always_comb begin
      case (trig_mode)
         2'd0:    start_s = fr_start_s;
         2'd1:    start_s = ext_start_s;
         2'd2:    start_s = sw_trigger;
         default: start_s = 1'b0;
      endcase
      run_done_s = ({1'b0, cyc_t_r} >= end_max_r);
      accept_s   = exposure_enable & start_s & ((state_r == ST_IDLE) | run_done_s);
      miss_s     = exposure_enable & start_s & (state_r == ST_RUN) & ~run_done_s;
   end

   // Per-channel window ends, their maximum, and the combinational channel windows
   always_comb begin
      end_max_s = {(TW+1){1'b0}};
      trig_s    = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         end_s[i] = {1'b0, delay_sh_r[i]} + {1'b0, width_sh_r[i]};
         if (end_s[i] > end_max_s)
            end_max_s = end_s[i];
         else
            end_max_s = end_max_s;
         trig_s[i] = (state_r == ST_RUN) && (cyc_t_r >= delay_sh_r[i]) && ({1'b0, cyc_t_r} < end_s[i]);
      end
   end

   // Shadow copies of the timing registers, taken only when a cycle is accepted
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < NUM_CH; i++) begin
            delay_sh_r[i] <= {TW{1'b0}};
            width_sh_r[i] <= {TW{1'b0}};
         end
      end else if (accept_s) begin
         for (int i = 0; i < NUM_CH; i++) begin
            delay_sh_r[i] <= EXP_DELAY[i*TW +: TW];
            width_sh_r[i] <= EXP_WIDTH[i*TW +: TW];
         end
      end
   end

   // Exposure FSM; end_max is parked at all-ones on acceptance so the cycle cannot end before it is valid
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_r     <= ST_IDLE;
         busy        <= 1'b0;
         cyc_t_r     <= {TW{1'b0}};
         end_max_r   <= {(TW+1){1'b0}};
         frame_count <= 16'd0;
         trig_missed <= 1'b0;
      end else begin
         trig_missed <= miss_s;
         end_max_r   <= end_max_s;
         if (!exposure_enable) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            cyc_t_r <= {TW{1'b0}};
         end else if (accept_s) begin
            state_r     <= ST_RUN;
            busy        <= 1'b1;
            cyc_t_r     <= {TW{1'b0}};
            end_max_r   <= {(TW+1){1'b1}};
            frame_count <= frame_count + 16'd1;
         end else begin
            case (state_r)
               ST_RUN: begin
                  if (run_done_s) begin
                     state_r <= ST_IDLE;
                     busy    <= 1'b0;
                  end else if (tick_us) begin
                     cyc_t_r <= cyc_t_r + {{(TW-1){1'b0}}, 1'b1};
                  end
               end
               ST_IDLE: begin
                  busy <= 1'b0;
               end
               default: begin
                  state_r <= ST_IDLE;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ref_trig_s   = sensor_trigger[STROBE_REF];
   assign strobe_inc_s = {1'b0, strobe_t_r} + {{TW{1'b0}}, 1'b1};

   // Registered channel outputs, strobe timer and strobe output
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sensor_trigger <= {NUM_CH{1'b0}};
         strobe_enable  <= 1'b0;
         strobe_t_r     <= {TW{1'b0}};
      end else if (!exposure_enable) begin
         sensor_trigger <= {NUM_CH{1'b0}};
         strobe_enable  <= 1'b0;
         strobe_t_r     <= {TW{1'b0}};
      end else begin
         sensor_trigger <= trig_s;
         strobe_enable  <= ref_trig_s && (strobe_t_r < STROBE_WIDTH);
         if (!ref_trig_s)
            strobe_t_r <= {TW{1'b0}};
         else if (tick_us)
            strobe_t_r <= (strobe_inc_s >= {1'b0, STROBE_PERIOD}) ? {TW{1'b0}} : strobe_inc_s[TW-1:0];
      end
   end

endmodule

// File: tb/tb_exposure_sequencer.sv
// Directed, table-driven bench for exposure_sequencer (default parameters).
module tb_exposure_sequencer;

`ifdef EXPOSURE_SEQ_TRIG_FILTER_EN
   localparam int  LAT          = 7;
   localparam logic SHORT_START = 1'b0;
`else
   localparam int  LAT          = 3;
   localparam logic SHORT_START = 1'b1;
`endif
   localparam int HOLD = (LAT + 1 >= 6) ? 0 : 6 - LAT - 1;

   logic        aclk = 1'b0;
   logic        aresetn, tick_us, tick_sec, external_trigger, sw_trigger, exposure_enable;
   logic [1:0]  trig_mode;
   logic [31:0] FRAME_PERIOD, STROBE_PERIOD, STROBE_WIDTH;
   logic [95:0] EXP_DELAY, EXP_WIDTH;
   logic [2:0]  sensor_trigger;
   logic        strobe_enable, busy, trig_missed;
   logic [15:0] frame_count;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_fc = 0;

   typedef struct {
      int         us;
      logic [2:0] trig;
      logic       strobe;
      logic       busy;
   } vec_t;
   vec_t tbl [14];

   exposure_sequencer dut (
      .aclk(aclk), .aresetn(aresetn), .tick_us(tick_us), .tick_sec(tick_sec),
      .external_trigger(external_trigger), .sw_trigger(sw_trigger), .trig_mode(trig_mode),
      .exposure_enable(exposure_enable), .FRAME_PERIOD(FRAME_PERIOD), .EXP_DELAY(EXP_DELAY),
      .EXP_WIDTH(EXP_WIDTH), .STROBE_PERIOD(STROBE_PERIOD), .STROBE_WIDTH(STROBE_WIDTH),
      .sensor_trigger(sensor_trigger), .strobe_enable(strobe_enable), .busy(busy),
      .frame_count(frame_count), .trig_missed(trig_missed)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic clk(input int n);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   // n microseconds: one tick_us cycle followed by three idle cycles each
   task automatic us(input int n);
      repeat (n) begin
         tick_us = 1'b1;
         clk(1);
         tick_us = 1'b0;
         clk(3);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cur;
      int n;
      tbl[0]  = '{0,  3'b001, 1'b1, 1'b1};
      tbl[1]  = '{2,  3'b001, 1'b1, 1'b1};
      tbl[2]  = '{3,  3'b001, 1'b0, 1'b1};
      tbl[3]  = '{10, 3'b011, 1'b1, 1'b1};
      tbl[4]  = '{20, 3'b111, 1'b1, 1'b1};
      tbl[5]  = '{39, 3'b111, 1'b0, 1'b1};
      tbl[6]  = '{40, 3'b101, 1'b1, 1'b1};
      tbl[7]  = '{42, 3'b101, 1'b1, 1'b1};
      tbl[8]  = '{43, 3'b101, 1'b0, 1'b1};
      tbl[9]  = '{49, 3'b101, 1'b0, 1'b1};
      tbl[10] = '{50, 3'b100, 1'b0, 1'b1};
      tbl[11] = '{59, 3'b100, 1'b0, 1'b1};
      tbl[12] = '{60, 3'b000, 1'b0, 1'b0};
      tbl[13] = '{99, 3'b000, 1'b0, 1'b0};

      aresetn = 1'b0; tick_us = 1'b0; tick_sec = 1'b0; external_trigger = 1'b0;
      sw_trigger = 1'b0; trig_mode = 2'd0; exposure_enable = 1'b1;
      FRAME_PERIOD = 32'd100; STROBE_PERIOD = 32'd10; STROBE_WIDTH = 32'd3;
      EXP_DELAY = {32'd20, 32'd10, 32'd0};
      EXP_WIDTH = {32'd40, 32'd30, 32'd50};
      clk(3);
      chk("reset_trig", sensor_trigger, 3'b000);
      chk("reset_strobe", strobe_enable, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_fc", frame_count, 16'd0);
      chk("reset_missed", trig_missed, 1'b0);
      aresetn = 1'b1;
      clk(2);

      // Free-run: frame timer wraps on the 100th tick
      us(99);
      chk("fr_pre_busy", busy, 1'b0);
      chk("fr_pre_fc", frame_count, 16'd0);
      us(1);
      exp_fc++;
      chk("fr1_fc", frame_count, exp_fc);
      cur = 0;
      for (int i = 0; i < 14; i++) begin
         us(tbl[i].us - cur);
         cur = tbl[i].us;
         chk($sformatf("fr_trig_us%0d", cur), sensor_trigger, tbl[i].trig);
         chk($sformatf("fr_strobe_us%0d", cur), strobe_enable, tbl[i].strobe);
         chk($sformatf("fr_busy_us%0d", cur), busy, tbl[i].busy);
      end
      us(1);
      exp_fc++;
      chk("fr2_fc", frame_count, exp_fc);
      chk("fr2_trig_us0", sensor_trigger, 3'b001);

      // PPS at us 57 of frame 2: counts as a missed start, frame timer realigns
      us(56);
      chk("pps_trig_us56", sensor_trigger, 3'b100);
      tick_sec = 1'b1;
      clk(1);
      tick_sec = 1'b0;
      chk("pps_missed", trig_missed, 1'b1);
      clk(1);
      chk("pps_missed_clr", trig_missed, 1'b0);
      us(3);
      chk("pps_trig_us59", sensor_trigger, 3'b100);
      chk("pps_busy_us59", busy, 1'b1);
      us(1);
      chk("pps_trig_us60", sensor_trigger, 3'b000);
      chk("pps_busy_us60", busy, 1'b0);
      us(95);
      chk("pps_fc_hold", frame_count, exp_fc);
      chk("pps_idle", busy, 1'b0);
      us(1);
      exp_fc++;
      chk("pps_new_fc", frame_count, exp_fc);
      chk("pps_new_trig", sensor_trigger, 3'b001);

      // exposure_enable dropped at us 15 aborts the cycle
      us(15);
      chk("en_trig_us15", sensor_trigger, 3'b011);
      exposure_enable = 1'b0;
      clk(1);
      exposure_enable = 1'b1;
      chk("en_trig_off", sensor_trigger, 3'b000);
      chk("en_strobe_off", strobe_enable, 1'b0);
      chk("en_busy_off", busy, 1'b0);
      chk("en_fc_hold", frame_count, exp_fc);
      us(15);
      chk("en_stay_idle", busy, 1'b0);
      chk("en_stay_low", sensor_trigger, 3'b000);
      us(70);
      exp_fc++;
      chk("en_next_fc", frame_count, exp_fc);
      chk("en_next_trig", sensor_trigger, 3'b001);

      // Disabled mode: frame timer wraps must not start anything
      trig_mode = 2'd3;
      us(101);
      chk("dis_busy", busy, 1'b0);
      chk("dis_fc", frame_count, exp_fc);

      // External mode with ch0 width 20, end_max 20
      EXP_DELAY = {32'd20, 32'd10, 32'd0};
      EXP_WIDTH = {32'd0, 32'd0, 32'd20};
      trig_mode = 2'd1;
      clk(2);
      external_trigger = 1'b1;
      clk(3);
      external_trigger = 1'b0;
      clk(12);
      if (SHORT_START) exp_fc++;
      chk("ext_short_busy", busy, SHORT_START);
      chk("ext_short_fc", frame_count, exp_fc);
      us(25);
      chk("ext_short_done", busy, 1'b0);

      external_trigger = 1'b1;
      n = 0;
      while (busy !== 1'b1 && n < 20) begin
         clk(1);
         n++;
      end
      chk("ext_latency", n, LAT);
      clk(1);
      chk("ext_trig_latency", sensor_trigger, 3'b001);
      clk(HOLD);
      external_trigger = 1'b0;
      clk(10);
      exp_fc++;
      chk("ext_fc", frame_count, exp_fc);

      EXP_WIDTH = {32'd0, 32'd0, 32'd5};
      us(9);
      chk("ext_midwrite_trig", sensor_trigger, 3'b001);
      external_trigger = 1'b1;
      clk(LAT);
      chk("ext_missed", trig_missed, 1'b1);
      clk(1);
      chk("ext_missed_pulse", trig_missed, 1'b0);
      clk(HOLD);
      external_trigger = 1'b0;
      clk(10);
      chk("ext_missed_fc", frame_count, exp_fc);
      chk("ext_missed_busy", busy, 1'b1);

      // Start captured exactly when cyc_t reaches end_max: back-to-back reload
      us(10);
      chk("b2b_trig_us19", sensor_trigger, 3'b001);
      external_trigger = 1'b1;
      clk(LAT - 2);
      tick_us = 1'b1;
      clk(1);
      tick_us = 1'b0;
      clk(1);
      exp_fc++;
      chk("b2b_no_miss", trig_missed, 1'b0);
      chk("b2b_busy", busy, 1'b1);
      chk("b2b_fc", frame_count, exp_fc);
      clk(3);
      external_trigger = 1'b0;
      chk("b2b_trig_us0", sensor_trigger, 3'b001);
      clk(10);
      us(5);
      chk("b2b_new_width", sensor_trigger, 3'b000);
      chk("b2b_still_busy", busy, 1'b1);
      us(16);
      chk("b2b_done", busy, 1'b0);

      // Software mode, then disabled mode ignores the software pulse
      trig_mode = 2'd2;
      sw_trigger = 1'b1;
      clk(1);
      sw_trigger = 1'b0;
      exp_fc++;
      chk("sw_busy", busy, 1'b1);
      chk("sw_fc", frame_count, exp_fc);
      us(21);
      chk("sw_done", busy, 1'b0);
      trig_mode = 2'd3;
      sw_trigger = 1'b1;
      clk(1);
      sw_trigger = 1'b0;
      clk(1);
      chk("sw_disabled_busy", busy, 1'b0);
      chk("sw_disabled_fc", frame_count, exp_fc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
